apb_fll_cfg_master: RTL and testbench

APB-to-FLL configuration initiator. It turns APB register accesses into four-phase req/ack transactions on the FLL configuration port: fll_req, fll_wrn, fll_add[1:0], fll_data[31:0], fll_ack, fll_r_data[31:0]. It sits in the SoC peripheral subsystem and connects to the clock/reset generator's FLL config and lock pins. It also exposes lock and error status.

---
 rtl/fll_cfg_pkg.sv | 12 +
 rtl/fll_cfg_sync.sv | 21 ++
 rtl/apb_fll_cfg_master.sv | 99 +++++++++
 tb/tb_apb_fll_cfg_master.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fll_cfg_pkg.sv
// fll_cfg_pkg: shared state encoding, register offsets and STATUS bit positions for the FLL config master
package fll_cfg_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_REL, ST_DONE, ST_ERR} fll_cfg_state_e;
   localparam logic [11:0] FLL_REG0_OFS   = 12'h000;
   localparam logic [11:0] FLL_REG1_OFS   = 12'h004;
   localparam logic [11:0] FLL_REG2_OFS   = 12'h008;
   localparam logic [11:0] FLL_REG3_OFS   = 12'h00C;
   localparam logic [11:0] FLL_STATUS_OFS = 12'h010;
   localparam int STATUS_LOCK_BIT    = 0;
   localparam int STATUS_BUSY_BIT    = 1;
   localparam int STATUS_TIMEOUT_BIT = 2;
endpackage

// File: rtl/fll_cfg_sync.sv
// fll_cfg_sync: two-flop synchronizer, asynchronous active-high reset to 0
module fll_cfg_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH-1:0] r_meta, r_sync;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= d_i;
         r_sync <= r_meta;
      end
   end
   assign q_o = r_sync;
endmodule

// File: rtl/apb_fll_cfg_master.sv
// apb_fll_cfg_master: APB slave that turns register accesses into four-phase req/ack FLL config transactions
module apb_fll_cfg_master
   import fll_cfg_pkg::*;
#(
   parameter bit SYNC_ACK       = 1'b1,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [11:0] paddr_i,
   input  logic [31:0] pwdata_i,
   input  logic        pwrite_i,
   input  logic        psel_i,
   input  logic        penable_i,
   output logic [31:0] prdata_o,
   output logic        pready_o,
   output logic        pslverr_o,
   output logic        fll_req_o,
   output logic        fll_wrn_o,
   output logic [1:0]  fll_add_o,
   output logic [31:0] fll_data_o,
   input  logic        fll_ack_i,
   input  logic [31:0] fll_r_data_i,
   input  logic        fll_lock_i
);
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   fll_cfg_state_e r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_rdata, w_status;
   logic          r_timeout;
   logic          w_ack_s, w_lock_s, w_fll_sel, w_status_sel, w_bad_sel, w_idle_acc, w_cnt_last, w_clr_timeout;

   fll_cfg_sync #(.WIDTH(1)) u_lock_sync (.clk_i(clk_i), .rst_i(rst_i), .d_i(fll_lock_i), .q_o(w_lock_s));

   generate
      if (SYNC_ACK) begin : g_ack_sync
         fll_cfg_sync #(.WIDTH(1)) u_ack_sync (.clk_i(clk_i), .rst_i(rst_i), .d_i(fll_ack_i), .q_o(w_ack_s));
      end else begin : g_ack_raw
         assign w_ack_s = fll_ack_i;
      end
   endgenerate

   assign w_fll_sel     = paddr_i inside {FLL_REG0_OFS, FLL_REG1_OFS, FLL_REG2_OFS, FLL_REG3_OFS};
   assign w_status_sel  = paddr_i == FLL_STATUS_OFS;
   assign w_bad_sel     = !w_fll_sel && !w_status_sel;
   assign w_idle_acc    = r_state == ST_IDLE && psel_i && penable_i;
   assign w_cnt_last    = r_cnt == CNT_LAST;
   assign w_clr_timeout = w_idle_acc && w_status_sel && pwrite_i && pwdata_i[STATUS_TIMEOUT_BIT];

   always_comb begin
      w_status                     = '0;
      w_status[STATUS_LOCK_BIT]    = w_lock_s;
      w_status[STATUS_BUSY_BIT]    = r_state != ST_IDLE;
      w_status[STATUS_TIMEOUT_BIT] = r_timeout;
   end

   // each handshake phase waits for its ack level, bounded by the shared counter
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: w_next = (w_idle_acc && w_fll_sel && !w_ack_s) ? ST_REQ : ST_IDLE;
         ST_REQ:  w_next = w_ack_s ? ST_REL : w_cnt_last ? ST_ERR : ST_REQ;
         ST_REL:  w_next = !w_ack_s ? ST_DONE : w_cnt_last ? ST_ERR : ST_REL;
         default: w_next = ST_IDLE;
      endcase
   end

   assign pready_o  = r_state == ST_DONE || r_state == ST_ERR || (w_idle_acc && !w_fll_sel);
   assign pslverr_o = r_state == ST_ERR || (w_idle_acc && w_bad_sel);
   assign prdata_o  = (r_state == ST_DONE && fll_wrn_o) ? r_rdata :
                      (w_idle_acc && w_status_sel) ? w_status : '0;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_rdata    <= '0;
         r_timeout  <= 1'b0;
         fll_req_o  <= 1'b0;
         fll_wrn_o  <= 1'b1;
         fll_add_o  <= '0;
         fll_data_o <= '0;
      end else begin
         r_state   <= w_next;
         r_cnt     <= (w_next == r_state) ? r_cnt + 1'b1 : '0;
         fll_req_o <= w_next == ST_REQ;
         r_timeout <= r_state == ST_ERR || (r_timeout && !w_clr_timeout);
         if (r_state == ST_IDLE && w_next == ST_REQ) begin
            fll_add_o  <= paddr_i[3:2];
            fll_wrn_o  <= !pwrite_i;
            fll_data_o <= pwdata_i;
         end
         if (r_state == ST_REQ && w_ack_s && fll_wrn_o)
            r_rdata <= fll_r_data_i;
      end
   end
endmodule

// File: tb/tb_apb_fll_cfg_master.sv
// tb_apb_fll_cfg_master: random APB traffic against two configurations, checked with a wait-state/register model
module tb_apb_fll_cfg_master;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   logic [11:0] paddr = '0;
   logic [31:0] pwdata = '0;
   logic pwrite = 1'b0, penable = 1'b0, lock = 1'b0;
   logic [1:0] psel = '0;
   logic [1:0][31:0] prdata, fdata, rdat;
   logic [1:0] pready, pslverr, req, wrn, ack;
   logic [1:0][1:0] add;
   logic [1:0][1:0] dly = '0;
   logic [1:0] req_q = '0;
   logic [31:0] mem [2][4] = '{default: '0};
   int pulses [2] = '{0, 0};
   int hi [2] = '{0, 0};
   int rmode [2] = '{0, 0};

   logic [31:0] exp_mem [2][4] = '{default: '0};
   bit exp_to [2] = '{0, 0};
   bit lock_m = 0;
   int tmo [2] = '{8, 16};
   int sync_lat [2] = '{0, 2};
   int vectors = 0, miscompares = 0;

   apb_fll_cfg_master #(.SYNC_ACK(1'b0), .TIMEOUT_CYCLES(8)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .paddr_i(paddr), .pwdata_i(pwdata), .pwrite_i(pwrite),
      .psel_i(psel[0]), .penable_i(penable), .prdata_o(prdata[0]), .pready_o(pready[0]),
      .pslverr_o(pslverr[0]), .fll_req_o(req[0]), .fll_wrn_o(wrn[0]), .fll_add_o(add[0]),
      .fll_data_o(fdata[0]), .fll_ack_i(ack[0]), .fll_r_data_i(rdat[0]), .fll_lock_i(lock));

   apb_fll_cfg_master #(.SYNC_ACK(1'b1), .TIMEOUT_CYCLES(16)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .paddr_i(paddr), .pwdata_i(pwdata), .pwrite_i(pwrite),
      .psel_i(psel[1]), .penable_i(penable), .prdata_o(prdata[1]), .pready_o(pready[1]),
      .pslverr_o(pslverr[1]), .fll_req_o(req[1]), .fll_wrn_o(wrn[1]), .fll_add_o(add[1]),
      .fll_data_o(fdata[1]), .fll_ack_i(ack[1]), .fll_r_data_i(rdat[1]), .fll_lock_i(lock));

   // responder modes: 0 ack follows req, 1 ack is req delayed 2 cycles, 2 never acks, 3 ack stuck high
   always_comb begin
      for (int d = 0; d < 2; d++) begin
         ack[d]  = rmode[d] == 0 ? req[d] : rmode[d] == 1 ? dly[d][1] : rmode[d] == 3;
         rdat[d] = ack[d] ? mem[d][add[d]] : 32'hBAD0_BAD0;
      end
   end

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         dly[d]   <= {dly[d][0], req[d]};
         req_q[d] <= req[d];
         if (req[d]) hi[d] <= hi[d] + 1;
         if (req[d] && !req_q[d]) begin
            pulses[d] <= pulses[d] + 1;
            if (!wrn[d]) mem[d][add[d]] <= fdata[d];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic apb_start(input int d, input logic [11:0] a, input bit w, input logic [31:0] wd);
      @(posedge clk); #1;
      paddr = a; pwrite = w; pwdata = wd; psel[d] = 1'b1; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
   endtask

   task automatic apb_wait(input int d, output logic [31:0] rd, output bit err, output int waits);
      waits = 0;
      forever begin
         @(negedge clk);
         if (pready[d]) break;
         waits++;
         if (waits > 300) begin
            chk("apb_hang", 32'd1, 32'd0);
            break;
         end
      end
      rd = prdata[d];
      err = pslverr[d];
   endtask

   task automatic apb_end(input int d);
      @(posedge clk); #1;
      psel[d] = 1'b0; penable = 1'b0;
   endtask

   task automatic xfer(input int d, input logic [11:0] a, input bit w, input logic [31:0] wd,
                       output logic [31:0] rd, output bit err, output int waits);
      apb_start(d, a, w, wd);
      apb_wait(d, rd, err, waits);
      apb_end(d);
   endtask

   function automatic int exp_waits(input int d, input int mode);
      return mode == 2 ? 1 + tmo[d] : 1 + 2 * (1 + (mode == 1 ? 2 : 0) + sync_lat[d]);
   endfunction

   function automatic logic [31:0] status_exp(input int d);
      return {29'd0, exp_to[d], 1'b0, lock_m};
   endfunction

   task automatic fll_op(input int d, input int mode, input logic [1:0] idx, input bit w, input logic [31:0] wd);
      logic [31:0] rd;
      bit err;
      int waits, p0;
      rmode[d] = mode;
      p0 = pulses[d];
      xfer(d, {8'd0, idx, 2'b00}, w, wd, rd, err, waits);
      chk($sformatf("d%0d_m%0d_waits", d, mode), waits, exp_waits(d, mode));
      chk($sformatf("d%0d_m%0d_err", d, mode), {31'd0, err}, {31'd0, mode == 2});
      chk($sformatf("d%0d_pulses", d), pulses[d] - p0, 32'd1);
      chk($sformatf("d%0d_add", d), {30'd0, add[d]}, {30'd0, idx});
      chk($sformatf("d%0d_wrn", d), {31'd0, wrn[d]}, {31'd0, !w});
      if (w) begin
         chk($sformatf("d%0d_wdata", d), fdata[d], wd);
         chk($sformatf("d%0d_wr_prdata", d), rd, 32'd0);
         exp_mem[d][idx] = wd;
      end else begin
         chk($sformatf("d%0d_rdata", d), rd, mode == 2 ? 32'd0 : exp_mem[d][idx]);
      end
      if (mode == 2) exp_to[d] = 1'b1;
   endtask

   task automatic status_rd(input int d, input string tag);
      logic [31:0] rd;
      bit err;
      int waits;
      xfer(d, 12'h010, 1'b0, 32'd0, rd, err, waits);
      chk({tag, "_val"}, rd, status_exp(d));
      chk({tag, "_waits"}, waits, 32'd0);
      chk({tag, "_err"}, {31'd0, err}, 32'd0);
   endtask

   task automatic status_wr(input int d, input logic [31:0] wd);
      logic [31:0] rd;
      bit err;
      int waits;
      xfer(d, 12'h010, 1'b1, wd, rd, err, waits);
      chk("st_wr_waits", waits, 32'd0);
      chk("st_wr_err", {31'd0, err}, 32'd0);
      if (wd[2]) exp_to[d] = 1'b0;
   endtask

   task automatic bad_op(input int d, input logic [11:0] a);
      logic [31:0] rd;
      bit err;
      int waits, p0;
      p0 = pulses[d];
      xfer(d, a, 1'($urandom_range(0, 1)), $urandom, rd, err, waits);
      chk($sformatf("bad_%h_waits", a), waits, 32'd0);
      chk($sformatf("bad_%h_err", a), {31'd0, err}, 32'd1);
      chk($sformatf("bad_%h_rd", a), rd, 32'd0);
      chk($sformatf("bad_%h_noreq", a), pulses[d] - p0, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, wd;
      bit err;
      int waits, h0, m;
      logic [11:0] a;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_req", {31'd0, req[d]}, 32'd0);
         chk("rst_wrn", {31'd0, wrn[d]}, 32'd1);
         chk("rst_add", {30'd0, add[d]}, 32'd0);
         chk("rst_data", fdata[d], 32'd0);
         chk("rst_pready", {31'd0, pready[d]}, 32'd0);
         chk("rst_pslverr", {31'd0, pslverr[d]}, 32'd0);
         chk("rst_prdata", prdata[d], 32'd0);
      end
      @(posedge clk); #1 rst = 1'b0;
      status_rd(0, "st0_init");
      status_rd(1, "st1_init");

      fll_op(0, 0, 2'd2, 1'b1, 32'hDEAD_BEEF);
      fll_op(1, 1, 2'd1, 1'b1, 32'h1234_5678);
      fll_op(1, 1, 2'd1, 1'b0, 32'd0);

      rmode[0] = 2;
      h0 = hi[0];
      fll_op(0, 2, 2'd3, 1'b0, 32'd0);
      chk("to_req_cycles", hi[0] - h0, 32'd8);
      status_rd(0, "st_to_set");
      status_wr(0, 32'h4);
      status_rd(0, "st_to_clr");

      bad_op(0, 12'h014);
      bad_op(1, 12'h002);

      for (int i = 0; i < 60; i++) begin
         int d;
         d = $urandom_range(0, 1);
         m = $urandom_range(0, 9);
         case ($urandom_range(0, 9))
            6: status_rd(d, "st_rand");
            7: status_wr(d, $urandom);
            8: begin
               a = 12'($urandom_range(0, 4095));
               if (a <= 12'h010 && a[1:0] == 2'b00) a[0] = 1'b1;
               bad_op(d, a);
            end
            default: fll_op(d, m < 5 ? 0 : m < 9 ? 1 : 2, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
         endcase
      end

      @(posedge clk); #1;
      paddr = 12'h010; pwrite = 1'b0; psel[0] = 1'b1; penable = 1'b1;
      @(posedge clk); #1 lock = 1'b1;
      @(negedge clk) chk("lock_c0", {31'd0, prdata[0][0]}, 32'd0);
      @(negedge clk) chk("lock_c1", {31'd0, prdata[0][0]}, 32'd0);
      @(negedge clk) chk("lock_c2", {31'd0, prdata[0][0]}, 32'd1);
      @(posedge clk); #1 psel[0] = 1'b0; penable = 1'b0;
      lock_m = 1'b1;

      rmode[0] = 1;
      apb_start(0, 12'h000, 1'b0, 32'd0);
      @(posedge clk); #1;
      @(negedge clk) chk("mid_req_high", {31'd0, req[0]}, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_req", {31'd0, req[0]}, 32'd0);
      chk("rst_mid_pready", {31'd0, pready[0]}, 32'd0);
      psel[0] = 1'b0; penable = 1'b0; rmode[0] = 3;
      exp_to[0] = 1'b0;
      @(posedge clk); #1 rst = 1'b0;

      wd = $urandom;
      apb_start(0, 12'h008, 1'b1, wd);
      repeat (4) begin
         @(negedge clk);
         chk("stall_pready", {31'd0, pready[0]}, 32'd0);
         chk("stall_req", {31'd0, req[0]}, 32'd0);
      end
      @(posedge clk); #1 rmode[0] = 0;
      apb_wait(0, rd, err, waits);
      apb_end(0);
      chk("post_rst_waits", waits, 32'd3);
      chk("post_rst_err", {31'd0, err}, 32'd0);
      chk("post_rst_data", fdata[0], wd);
      exp_mem[0][2] = wd;
      fll_op(0, 0, 2'd2, 1'b0, 32'd0);
      repeat (2) @(posedge clk);
      status_rd(0, "st_final");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
